// File: rtl/vend_credit_ctrl.sv
// Credit-and-dispense controller for the newspaper vending machine.
// Collects coin credit, runs the paper-release handshake, then refunds change one nickel at a time.
module vend_credit_ctrl #(
   parameter int PRICE    = 15,
   parameter int CREDIT_W = 6,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                vend_ack,
   input  logic                change_ack,
   output logic                vend_req,
   output logic                change_req,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } state_t;

   localparam logic [CREDIT_W-1:0] C_PRICE      = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] C_NICKEL     = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] C_ZERO       = {CREDIT_W{1'b0}};
   localparam logic [7:0]          C_TIMER_LAST = 8'(TIMEOUT - 1);

   function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
      logic [CREDIT_W-1:0] v;
      case (code)
         2'b01:   v = CREDIT_W'(5);
         2'b10:   v = CREDIT_W'(10);
         2'b11:   v = CREDIT_W'(25);
         default: v = C_ZERO;
      endcase
      return v;
   endfunction

   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [7:0]          r_timer;
   logic                r_vend_req;
   logic                r_change_req;
   logic                r_coin_reject;
   logic                r_busy;

   state_t              w_state_nx;
   logic [CREDIT_W-1:0] w_credit_nx;
   logic [7:0]          w_timer_nx;
   logic                w_reject_nx;
   logic                w_coin_vld;
   logic [CREDIT_W-1:0] w_credit_add;
   logic [CREDIT_W-1:0] w_credit_vend;
   logic [CREDIT_W-1:0] w_credit_nickel;

   assign w_coin_vld   = (coin != 2'b00);
   assign w_credit_add = r_credit + coin_value(coin);
   // Saturating subtractions keep credit from wrapping even if state were ever corrupted.
   assign w_credit_vend   = (r_credit >= C_PRICE)  ? (r_credit - C_PRICE)  : C_ZERO;
   assign w_credit_nickel = (r_credit >= C_NICKEL) ? (r_credit - C_NICKEL) : C_ZERO;

   // Next-state, credit, timer and reject decision.
   always_comb begin
      w_state_nx  = r_state;
      w_credit_nx = r_credit;
      w_timer_nx  = 8'd0;
      w_reject_nx = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_coin_vld) begin
               w_credit_nx = w_credit_add;
               if (w_credit_add >= C_PRICE) begin
                  w_state_nx = S_VEND;
               end else begin
                  w_state_nx = S_COLLECT;
               end
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_COLLECT: begin
            if (cancel) begin
               w_reject_nx = w_coin_vld;
               w_state_nx  = S_CHANGE;
            end else if (w_coin_vld) begin
               w_credit_nx = w_credit_add;
               if (w_credit_add >= C_PRICE) begin
                  w_state_nx = S_VEND;
               end else begin
                  w_state_nx = S_COLLECT;
               end
            end else if (r_timer == C_TIMER_LAST) begin
               w_state_nx = S_CHANGE;
            end else begin
               w_timer_nx = r_timer + 8'd1;
            end
         end
         S_VEND: begin
            w_reject_nx = w_coin_vld;
            if (vend_ack) begin
               w_credit_nx = w_credit_vend;
               if (w_credit_vend != C_ZERO) begin
                  w_state_nx = S_CHANGE;
               end else begin
                  w_state_nx = S_IDLE;
               end
            end else begin
               w_state_nx = S_VEND;
            end
         end
         S_CHANGE: begin
            w_reject_nx = w_coin_vld;
            if (r_credit == C_ZERO) begin
               w_state_nx = S_IDLE;
            end else if (change_ack) begin
               w_credit_nx = w_credit_nickel;
               if (w_credit_nickel == C_ZERO) begin
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_CHANGE;
               end
            end else begin
               w_state_nx = S_CHANGE;
            end
         end
         default: begin
            w_state_nx  = S_IDLE;
            w_credit_nx = C_ZERO;
         end
      endcase
   end

   // State register; outputs are derived from the next state so they stay registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_credit      <= C_ZERO;
         r_timer       <= 8'd0;
         r_vend_req    <= 1'b0;
         r_change_req  <= 1'b0;
         r_coin_reject <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_credit      <= w_credit_nx;
         r_timer       <= w_timer_nx;
         r_vend_req    <= (w_state_nx == S_VEND);
         r_change_req  <= (w_state_nx == S_CHANGE) && (w_credit_nx != C_ZERO);
         r_coin_reject <= w_reject_nx;
         r_busy        <= (w_state_nx != S_IDLE);
      end
   end

   assign vend_req    = r_vend_req;
   assign change_req  = r_change_req;
   assign coin_reject = r_coin_reject;
   assign credit      = r_credit;
   assign busy        = r_busy;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl: a behavioural model fills a scoreboard
// queue as each cycle is driven, and registered outputs are popped and compared after the edge.
module tb_vend_credit_ctrl;

   localparam int PRICE = 15;
   localparam int CW    = 6;
   localparam int TO    = 4;

   localparam int M_IDLE    = 0;
   localparam int M_COLLECT = 1;
   localparam int M_VEND    = 2;
   localparam int M_CHANGE  = 3;

   typedef struct packed {
      logic [CW-1:0] credit;
      logic          vreq;
      logic          creq;
      logic          rej;
      logic          busy;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    coin = 2'b00;
   logic          cancel = 1'b0;
   logic          vend_ack = 1'b0;
   logic          change_ack = 1'b0;
   logic          vend_req;
   logic          change_req;
   logic          coin_reject;
   logic [CW-1:0] credit;
   logic          busy;

   exp_t sb_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   string cur_test = "init";

   int m_st = M_IDLE;
   int m_cr = 0;
   int m_tmr = 0;
   bit m_rej = 1'b0;

   int vend_cnt = 0;
   int eject_cnt = 0;
   int creq_cycles = 0;
   int rej_cycles = 0;

   vend_credit_ctrl #(.PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .coin(coin), .cancel(cancel),
      .vend_ack(vend_ack), .change_ack(change_ack),
      .vend_req(vend_req), .change_req(change_req), .coin_reject(coin_reject),
      .credit(credit), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s/%s: observed %0d expected %0d", cur_test, tag, obs, exp);
   endtask

   task automatic begin_test(input string name);
      cur_test = name;
      vend_cnt = 0;
      eject_cnt = 0;
      creq_cycles = 0;
      rej_cycles = 0;
   endtask

   task automatic model_step(input logic [1:0] c, input logic cn, input logic va, input logic ca);
      int val;
      val = (c == 2'd1) ? 5 : (c == 2'd2) ? 10 : (c == 2'd3) ? 25 : 0;
      m_rej = 1'b0;
      case (m_st)
         M_IDLE: if (val > 0) begin
            m_cr += val;
            m_tmr = 0;
            m_st = (m_cr >= PRICE) ? M_VEND : M_COLLECT;
         end
         M_COLLECT: begin
            if (cn) begin
               m_rej = (val > 0);
               m_st = M_CHANGE;
            end else if (val > 0) begin
               m_cr += val;
               m_tmr = 0;
               if (m_cr >= PRICE) m_st = M_VEND;
            end else begin
               m_tmr++;
               if (m_tmr == TO) m_st = M_CHANGE;
            end
         end
         M_VEND: begin
            m_rej = (val > 0);
            if (va) begin
               m_cr -= PRICE;
               m_st = (m_cr > 0) ? M_CHANGE : M_IDLE;
            end
         end
         default: begin
            m_rej = (val > 0);
            if (ca && m_cr > 0) m_cr -= 5;
            if (m_cr == 0) m_st = M_IDLE;
         end
      endcase
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.credit = CW'(m_cr);
      e.vreq   = (m_st == M_VEND);
      e.creq   = (m_st == M_CHANGE) && (m_cr > 0);
      e.rej    = m_rej;
      e.busy   = (m_st != M_IDLE);
      return e;
   endfunction

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_total++;
         $error("FAIL %s/sb_underflow: observed empty queue expected entry", cur_test);
      end else begin
         e = sb_q.pop_front();
         chk("credit", 32'(credit), 32'(e.credit));
         chk("vend_req", 32'(vend_req), 32'(e.vreq));
         chk("change_req", 32'(change_req), 32'(e.creq));
         chk("coin_reject", 32'(coin_reject), 32'(e.rej));
         chk("busy", 32'(busy), 32'(e.busy));
      end
      if (change_req === 1'b1) creq_cycles++;
      if (coin_reject === 1'b1) rej_cycles++;
   endtask

   task automatic cyc(input logic [1:0] c, input logic cn, input logic va, input logic ca);
      coin = c;
      cancel = cn;
      vend_ack = va;
      change_ack = ca;
      if (vend_req === 1'b1 && va) vend_cnt++;
      if (change_req === 1'b1 && ca) eject_cnt++;
      model_step(c, cn, va, ca);
      sb_q.push_back(model_out());
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      coin = 2'b00;
      cancel = 1'b0;
      vend_ack = 1'b0;
      change_ack = 1'b0;
      m_st = M_IDLE;
      m_cr = 0;
      m_tmr = 0;
      m_rej = 1'b0;
      sb_q.push_back(model_out());
      @(posedge clk);
      #1;
      check_out();
      chk("state", 32'(dut.r_state), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      begin_test("reset");
      do_reset();

      begin_test("three_nickels");
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      chk("credit_5", 32'(credit), 32'd5);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      chk("credit_10", 32'(credit), 32'd10);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      chk("credit_15", 32'(credit), 32'd15);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      cyc(2'd0, 1'b0, 1'b1, 1'b0);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("vend_handshakes", 32'(vend_cnt), 32'd1);
      chk("change_req_cycles", 32'(creq_cycles), 32'd0);
      chk("idle_credit", 32'(credit), 32'd0);

      begin_test("quarter");
      cyc(2'd3, 1'b0, 1'b1, 1'b1);
      chk("vend_next", 32'(vend_req), 32'd1);
      cyc(2'd0, 1'b0, 1'b1, 1'b1);
      chk("after_vend", 32'(credit), 32'd10);
      cyc(2'd0, 1'b0, 1'b1, 1'b1);
      cyc(2'd0, 1'b0, 1'b1, 1'b1);
      cyc(2'd0, 1'b0, 1'b1, 1'b1);
      chk("ejects", 32'(eject_cnt), 32'd2);
      chk("idle_busy", 32'(busy), 32'd0);

      begin_test("dime_cancel");
      cyc(2'd2, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b1, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("vend_handshakes", 32'(vend_cnt), 32'd0);
      chk("ejects", 32'(eject_cnt), 32'd2);
      chk("idle_credit", 32'(credit), 32'd0);

      begin_test("timeout");
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < TO - 1; i++) cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("still_collect", 32'(change_req), 32'd0);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("change_at_n5", 32'(change_req), 32'd1);
      chk("refund_credit", 32'(credit), 32'd5);
      cyc(2'd0, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("ejects", 32'(eject_cnt), 32'd1);

      begin_test("late_ack");
      cyc(2'd2, 1'b0, 1'b0, 1'b0);
      cyc(2'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc((i == 2) ? 2'd3 : 2'd0, (i == 5), 1'b0, 1'b0);
      chk("held_credit", 32'(credit), 32'd20);
      chk("reject_pulses", 32'(rej_cycles), 32'd1);
      cyc(2'd0, 1'b0, 1'b1, 1'b0);
      chk("after_vend", 32'(credit), 32'd5);
      cyc(2'd0, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("ejects", 32'(eject_cnt), 32'd1);

      begin_test("cancel_coin");
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      cyc(2'd2, 1'b1, 1'b0, 1'b0);
      chk("cancel_credit", 32'(credit), 32'd5);
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      cyc(2'd0, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("reject_pulses", 32'(rej_cycles), 32'd2);

      begin_test("reset_mid_vend");
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      cyc(2'd2, 1'b0, 1'b0, 1'b0);
      chk("vend_req_high", 32'(vend_req), 32'd1);
      do_reset();
      cyc(2'd1, 1'b0, 1'b0, 1'b0);
      chk("post_reset_credit", 32'(credit), 32'd5);
      cyc(2'd0, 1'b1, 1'b0, 1'b0);
      cyc(2'd0, 1'b0, 1'b0, 1'b1);
      cyc(2'd0, 1'b0, 1'b0, 1'b0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
